// File: rtl/bfly_mac_seq.sv
// bfly_mac_seq: handshaked radix-2 complex butterfly (A +/- B*W) using one shared multiplier over four cycles,
// with inverse (conj W) mode, optional /2 scaling and saturating outputs with an overflow flag.
module bfly_mac_seq #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 10
) (
    input  logic                    clk_MAC,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] a_re,
    input  logic signed [WIDTH-1:0] a_im,
    input  logic signed [WIDTH-1:0] b_re,
    input  logic signed [WIDTH-1:0] b_im,
    input  logic signed [WIDTH-1:0] w_re,
    input  logic signed [WIDTH-1:0] w_im,
    input  logic                    inverse,
    input  logic                    scale,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] out1_re,
    output logic signed [WIDTH-1:0] out1_im,
    output logic signed [WIDTH-1:0] out2_re,
    output logic signed [WIDTH-1:0] out2_im,
    output logic                    ovf
);
    localparam int AW = 2 * WIDTH + 1;
    localparam int PW = WIDTH + 2;
    localparam int SW = WIDTH + 3;
    localparam logic signed [AW-1:0] HALF = {{(AW-1){1'b0}}, 1'b1} << (FRAC - 1);
    localparam logic signed [SW-1:0] ONE = {{(SW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, BF, DONE} state_t;

    state_t                  state_q, state_d;
    logic signed [WIDTH-1:0] a_re_q, a_im_q, b_re_q, b_im_q, w_re_q, w_im_q;
    logic                    inv_q, sc_q;
    logic signed [AW-1:0]    acc_q, acc_d, acc2_q, acc2_d;
    logic [3:0][WIDTH-1:0]   res_q, res_d;
    logic [3:0]              sat;
    logic                    ovf_q, out_valid_q;
    logic signed [WIDTH-1:0] mul_a, mul_b;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [AW-1:0]    prod_x;
    logic signed [PW-1:0]    p_re, p_im;

    function automatic logic signed [PW-1:0] rnd(input logic signed [AW-1:0] x);
        return PW'((x + HALF) >>> FRAC);
    endfunction

    // Returns {saturated, value}; saturation iff the bits above the sign position disagree.
    function automatic logic [WIDTH:0] bf(input logic signed [WIDTH-1:0] a, input logic signed [PW-1:0] p,
                                          input logic sub, input logic sc);
        logic signed [SW-1:0] s;
        logic o;
        s = sub ? SW'(a) - SW'(p) : SW'(a) + SW'(p);
        s = sc ? (s + ONE) >>> 1 : s;
        o = !((&s[SW-1:WIDTH-1]) || !(|s[SW-1:WIDTH-1]));
        return {o, o ? {s[SW-1], {(WIDTH-1){~s[SW-1]}}} : s[WIDTH-1:0]};
    endfunction

    // Operand steering for the single multiplier: M0 bre*wre, M1 bim*wim, M2 bre*wim, M3 bim*wre.
    assign mul_a  = (state_q == M0 || state_q == M2) ? b_re_q : b_im_q;
    assign mul_b  = (state_q == M0 || state_q == M3) ? w_re_q : w_im_q;
    assign prod   = mul_a * mul_b;
    assign prod_x = AW'(prod);

    always_comb begin
        acc_d  = (state_q == M0) ? prod_x :
                 (state_q == M1) ? (inv_q ? acc_q + prod_x : acc_q - prod_x) : acc_q;
        acc2_d = (state_q == M2) ? (inv_q ? -prod_x : prod_x) :
                 (state_q == M3) ? acc2_q + prod_x : acc2_q;
    end

    assign p_re = rnd(acc_q);
    assign p_im = rnd(acc2_q);
    assign {sat[0], res_d[0]} = bf(a_re_q, p_re, 1'b0, sc_q);
    assign {sat[1], res_d[1]} = bf(a_im_q, p_im, 1'b0, sc_q);
    assign {sat[2], res_d[2]} = bf(a_re_q, p_re, 1'b1, sc_q);
    assign {sat[3], res_d[3]} = bf(a_im_q, p_im, 1'b1, sc_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? M0 : IDLE;
            M0:      state_d = M1;
            M1:      state_d = M2;
            M2:      state_d = M3;
            M3:      state_d = BF;
            BF:      state_d = DONE;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_MAC or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            a_re_q      <= '0;
            a_im_q      <= '0;
            b_re_q      <= '0;
            b_im_q      <= '0;
            w_re_q      <= '0;
            w_im_q      <= '0;
            inv_q       <= 1'b0;
            sc_q        <= 1'b0;
            acc_q       <= '0;
            acc2_q      <= '0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            acc2_q      <= acc2_d;
            out_valid_q <= (state_d == DONE);
            if (state_q == IDLE && in_valid) begin
                a_re_q <= a_re;
                a_im_q <= a_im;
                b_re_q <= b_re;
                b_im_q <= b_im;
                w_re_q <= w_re;
                w_im_q <= w_im;
                inv_q  <= inverse;
                sc_q   <= scale;
            end
            if (state_q == BF) begin
                res_q <= res_d;
                ovf_q <= |sat;
            end
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign out1_re   = res_q[0];
    assign out1_im   = res_q[1];
    assign out2_re   = res_q[2];
    assign out2_im   = res_q[3];
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_bfly_mac_seq.sv
// tb_bfly_mac_seq: directed-vector bench for bfly_mac_seq (WIDTH=16, FRAC=10) with hand-computed expectations.
module tb_bfly_mac_seq;
    logic               clk, rst, in_valid, in_ready, inverse, scale, out_valid, out_ready, ovf;
    logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic signed [15:0] out1_re, out1_im, out2_re, out2_im;
    int                 n_tests = 0;
    int                 n_fail  = 0;

    bfly_mac_seq #(.WIDTH(16), .FRAC(10)) dut (
        .clk_MAC(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .inverse(inverse), .scale(scale), .out_valid(out_valid), .out_ready(out_ready),
        .out1_re(out1_re), .out1_im(out1_im), .out2_re(out2_re), .out2_im(out2_im), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic start(input logic signed [15:0] ar, ai, br, bi, wr, wi, input logic inv, sc,
                         input string tag);
        int lat;
        check({tag, "/in_ready"}, 16'(in_ready), 16'd1);
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
        inverse = inv; scale = sc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "/latency"}, 16'(lat), 16'd5);
    endtask

    task automatic op(input logic signed [15:0] ar, ai, br, bi, wr, wi, input logic inv, sc,
                      input logic signed [15:0] e1r, e1i, e2r, e2i, input logic eovf, input string tag);
        out_ready = 1'b1;
        start(ar, ai, br, bi, wr, wi, inv, sc, tag);
        check({tag, "/out1_re"}, out1_re, e1r);
        check({tag, "/out1_im"}, out1_im, e1i);
        check({tag, "/out2_re"}, out2_re, e2r);
        check({tag, "/out2_im"}, out2_im, e2i);
        check({tag, "/ovf"}, 16'(ovf), 16'(eovf));
        @(posedge clk); #1;
        check({tag, "/valid_drop"}, 16'(out_valid), 16'd0);
        check({tag, "/idle"}, 16'(in_ready), 16'd1);
    endtask

    initial begin
        int c, seen;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; inverse = 1'b0; scale = 1'b0;
        a_re = 0; a_im = 0; b_re = 0; b_im = 0; w_re = 0; w_im = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/in_ready", 16'(in_ready), 16'd1);
        check("rst/out_valid", 16'(out_valid), 16'd0);
        check("rst/out1_re", out1_re, 16'sd0);
        check("rst/out2_im", out2_im, 16'sd0);
        check("rst/ovf", 16'(ovf), 16'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        op(1024, 512, 512, 256, 0, -1024, 0, 0, 1280, 0, 768, 1024, 0, "fwd");
        op(1024, 512, 512, 256, 0, -1024, 1, 0, 768, 1024, 1280, 0, 0, "inv");
        op(1024, 512, 512, 256, 0, -1024, 0, 1, 640, 0, 384, 512, 0, "fwd_scale");
        op(32767, 0, 1024, 0, 1024, 0, 0, 0, 32767, 0, 31743, 0, 1, "sat");
        op(32767, 0, 1024, 0, 1024, 0, 0, 1, 16896, 0, 15872, 0, 0, "sat_scale");
        op(0, 0, 1, 0, 512, 0, 0, 0, 1, 0, -1, 0, 0, "rnd_pos");
        op(0, 0, -1, 0, 512, 0, 0, 0, 0, 0, 0, 0, 0, "rnd_neg");
        op(3, 0, 0, 0, 512, 0, 0, 1, 2, 0, 2, 0, 0, "rnd_scale");

        // Stall in DONE for 10 cycles while in_valid pulses with different operands.
        out_ready = 1'b0;
        start(32767, 0, 1024, 0, 1024, 0, 0, 0, "stall");
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a_re = 16'(i * 100);
            b_re = 16'(i);
            @(posedge clk); #1;
            check("stall/out_valid", 16'(out_valid), 16'd1);
            check("stall/in_ready", 16'(in_ready), 16'd0);
            check("stall/out1_re", out1_re, 16'sd32767);
            check("stall/out2_re", out2_re, 16'sd31743);
            check("stall/ovf", 16'(ovf), 16'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release/out_valid", 16'(out_valid), 16'd0);
        check("release/in_ready", 16'(in_ready), 16'd1);
        check("release/out1_re_hold", out1_re, 16'sd32767);
        check("release/out2_re_hold", out2_re, 16'sd31743);
        @(posedge clk); #1;
        check("release/no_accept", 16'(in_ready), 16'd1);

        // Back-to-back acceptance with in_valid and out_ready held high.
        a_re = 1024; a_im = 512; b_re = 512; b_im = 256; w_re = 0; w_im = -1024;
        inverse = 1'b0; scale = 1'b0; in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            check("b2b/busy", 16'(in_ready), 16'd0);
            c = 0;
            while (!in_ready && c < 20) begin
                @(posedge clk); #1;
                c++;
            end
            check("b2b/interval", 16'(c + 1), 16'd7);
            check("b2b/out1_re", out1_re, 16'sd1280);
            check("b2b/out2_im", out2_im, 16'sd1024);
        end
        in_valid = 1'b0;

        // Asynchronous reset while the operation sits in M2.
        a_re = 32767; a_im = 0; b_re = 1024; b_im = 0; w_re = 1024; w_im = 0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("abort/out_valid", 16'(out_valid), 16'd0);
        check("abort/out1_re", out1_re, 16'sd0);
        check("abort/out1_im", out1_im, 16'sd0);
        check("abort/ovf", 16'(ovf), 16'd0);
        @(posedge clk); #2;
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("abort/never_valid", 16'(seen), 16'd0);
        op(1024, 512, 512, 256, 0, -1024, 0, 0, 1280, 0, 768, 1024, 0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bfly_mac_seq.md
# bfly_mac_seq

Parametrised, handshaked radix-2 butterfly engine for the 32-point FFT datapath. It computes out1 = A + B·W and out2 = A − B·W on complex fixed-point operands using one shared real multiplier over four cycles. It adds three things the fixed 16-bit MAC lacks: an inverse-FFT mode (conjugated twiddle), per-operation ÷2 stage scaling, and saturating outputs with an overflow flag. It sits between the operand memory/address sequencer and the stage write-back buffer.

## Interface
- WIDTH, 16, signed two's-complement word width of every data port
- FRAC, 10, fractional bits (1.0 = 2^FRAC); must satisfy 1 ≤ FRAC < WIDTH
- clk_MAC  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand set valid
- in_ready  out  1  block can accept operands
- a_re, a_im, b_re, b_im, w_re, w_im  in  WIDTH each  operands A, B, twiddle W
- inverse  in  1  1 = use conj(W); sampled with operands
- scale  in  1  1 = divide both results by 2; sampled with operands
- out_valid  out  1  results valid
- out_ready  in  1  downstream accepts results
- out1_re, out1_im, out2_re, out2_im  out  WIDTH each  results
- ovf  out  1  at least one of the four results saturated in this operation

## Operation
- FSM states: IDLE → M0 → M1 → M2 → M3 → BF → DONE → IDLE.
- in_ready = 1 only in IDLE. Acceptance is in_valid & in_ready at a rising edge. On acceptance, all operands plus inverse and scale are registered and the state goes to M0. Inputs are ignored in every other state.
- Exactly one signed WIDTH×WIDTH multiplier is instantiated. Let wi' = −w_im if inverse, else w_im. Negation is done in the accumulator add/sub, never by negating the operand, so w_im = most-negative is safe.
  - M0: acc = b_re·w_re
  - M1: acc = acc − b_im·wi'
  - M2: acc2 = b_re·wi'
  - M3: acc2 = acc2 + b_im·w_re
- Accumulators are 2·WIDTH+1 bits wide and never overflow.
- Product rounding (in BF): p = (acc + 2^(FRAC−1)) >>> FRAC, round-half-up, arithmetic shift. The same applies to acc2. Result kept at WIDTH+2 bits with no saturation here.
- BF, per component, in WIDTH+3 bits:
  - s1 = a + p, s2 = a − p
  - if scale: s = (s + 1) >>> 1
  - saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1]
- Results are registered on the BF→DONE edge. ovf is registered at the same edge as the OR of the four saturation events.
- DONE: out_valid = 1. Outputs and ovf are held stable while out_ready = 0. When out_ready = 1 at an edge, go to IDLE and drop out_valid.
- After leaving DONE, output data and ovf keep their last values until the next BF→DONE edge.
- Reset (any state, asynchronous assertion): state = IDLE, in_ready = 1 after release, out_valid = 0, all data outputs = 0, ovf = 0, accumulators = 0. An in-flight operation is discarded and never produces out_valid.

## Timing
- Acceptance at edge E0 → out_valid high after edge E5 (5-cycle latency).
- Minimum initiation interval is 7 cycles: with out_ready held high, DONE→IDLE at E6 and the next acceptance at E7.
- in_ready is low from E0 until the edge that leaves DONE.
- out_valid is registered. in_ready is decoded from the state register with no combinational path from any input.
- out_ready low stalls DONE indefinitely. No data is lost or altered during the stall.
- in_valid asserted while in_ready = 0 has no effect, and the operands are not queued.

## Test plan
- Forward: WIDTH=16, FRAC=10, A=(1024,512), B=(512,256), W=(0,−1024), inverse=0, scale=0 → out1=(1280,0), out2=(768,1024), ovf=0; out_valid exactly 5 cycles after acceptance.
- Inverse/scale: same operands with inverse=1 → out1=(768,1024), out2=(1280,0). Forward with scale=1 → out1=(640,0), out2=(384,512).
- Saturation: A=(32767,0), B=(1024,0), W=(1024,0) → out1=(32767,0), out2=(31743,0), ovf=1. Same with scale=1 → out1=(16896,0), out2=(15872,0), ovf=0.
- Rounding: A=0, W=(512,0):
  - B=(1,0) → out1=(1,0), out2=(−1,0)
  - B=(−1,0) → out1=(0,0), out2=(0,0)
  - A=(3,0), B=0, scale=1 → out1=(2,0), out2=(2,0)
- Handshake:
  - hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, in_valid pulses ignored
  - release → one-cycle handshake, IDLE next cycle
  - back-to-back ops with out_ready=1 → 7-cycle interval
- Reset: assert rst low during M2 → outputs 0, out_valid 0 immediately. After release, the next operation returns correct results and the aborted one never appears.
